// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: widths, bubble encoding and
// the IF/ID register layout that the decode stage also consumes.
package pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    // Instruction fetches are always word aligned; low bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter register with next-PC selection (redirect, hold, advance)
// and a one-cycle flag for misaligned redirect targets.
module pc_gen
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        misalign
);

    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc_next;
    logic            misalign_p0;

    // Flush does not appear here: a bubbled fetch still advances the PC.
    always_comb begin
        pc_next = pc_p0 + 32'd4;
        if (redirect) begin
            pc_next = align_word(redirect_pc);
        end else if (stall) begin
            pc_next = pc_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0       <= RESET_PC;
            misalign_p0 <= 1'b0;
        end else begin
            pc_p0       <= pc_next;
            misalign_p0 <= redirect & (|redirect_pc[1:0]);
        end
    end

    assign pc       = pc_p0;
    assign misalign = misalign_p0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction memory from the PC and
// captures instruction, PC and PC+4 into the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instr_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);
    import pipe_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            accept;
    if_id_t          if_id_p1;
    logic [XLEN-1:0] count_p1;

    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] val);
        return (&val) ? val : val + 32'd1;
    endfunction

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall_i),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .pc          (pc),
        .misalign    (misalign_o)
    );

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr_o = pc;
    // Memory data is only looked at on accepting edges so garbage during
    // stall/redirect/flush never reaches IF/ID.
    assign accept      = !redirect_i && !stall_i && !flush_i;

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_p1.valid <= 1'b0;
            if_id_p1.pc    <= '0;
            if_id_p1.pc4   <= '0;
            if_id_p1.instr <= NOP_INSTR;
            count_p1       <= '0;
        end else if (redirect_i || (flush_i && !stall_i)) begin
            if_id_p1.valid <= 1'b0;
            if_id_p1.pc    <= pc;
            if_id_p1.pc4   <= pc_plus4;
            if_id_p1.instr <= NOP_INSTR;
        end else if (accept) begin
            if_id_p1.valid <= 1'b1;
            if_id_p1.pc    <= pc;
            if_id_p1.pc4   <= pc_plus4;
            if_id_p1.instr <= imem_rdata_i;
            count_p1       <= sat_inc(count_p1);
        end
    end

    assign id_valid_o    = if_id_p1.valid;
    assign id_pc_o       = if_id_p1.pc;
    assign id_pc4_o      = if_id_p1.pc4;
    assign id_instr_o    = if_id_p1.instr;
    assign fetch_count_o = count_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main flow plus
// hand-written stall and reset-during-control sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic [31:0] id_instr_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;
    logic        garbage;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .id_instr_o    (id_instr_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    function automatic logic [31:0] ins(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0010_2083 : (32'hA000_0000 | a);
    endfunction

    // Instruction memory model; "garbage" models an undefined read word.
    always_comb imem_rdata_i = garbage ? 32'hDEAD_BEEF : ins(imem_addr_o);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
        logic        exp_mis;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic s, input logic f, input logic r,
                                input logic [31:0] rpc, input logic v,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] addr, input logic mis,
                                input logic [31:0] cnt);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.rpc = rpc;
        t.exp_valid = v; t.exp_pc = pc; t.exp_instr = instr;
        t.exp_addr = addr; t.exp_mis = mis; t.exp_cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic rd,
                         input logic [31:0] rpc);
        reset = r; stall_i = s; flush_i = f; redirect_i = rd; redirect_pc_i = rpc;
        garbage = s | rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 32'h0,        1, 32'h0,        32'h0010_2083,  32'h4,        0, 1);
        tbl[1]  = mk(0, 0, 0, 32'h0,        1, 32'h4,        ins(32'h4),     32'h8,        0, 2);
        tbl[2]  = mk(0, 0, 0, 32'h0,        1, 32'h8,        ins(32'h8),     32'hC,        0, 3);
        tbl[3]  = mk(0, 0, 0, 32'h0,        1, 32'hC,        ins(32'hC),     32'h10,       0, 4);
        tbl[4]  = mk(1, 0, 0, 32'h0,        1, 32'hC,        ins(32'hC),     32'h10,       0, 4);
        tbl[5]  = mk(1, 1, 0, 32'h0,        1, 32'hC,        ins(32'hC),     32'h10,       0, 4);
        tbl[6]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        NOP,            32'h14,       0, 4);
        tbl[7]  = mk(0, 0, 0, 32'h0,        1, 32'h14,       ins(32'h14),    32'h18,       0, 5);
        tbl[8]  = mk(1, 0, 1, 32'h20,       0, 32'h0,        NOP,            32'h20,       0, 5);
        tbl[9]  = mk(0, 0, 0, 32'h0,        1, 32'h20,       ins(32'h20),    32'h24,       0, 6);
        tbl[10] = mk(0, 0, 1, 32'h12,       0, 32'h0,        NOP,            32'h10,       1, 6);
        tbl[11] = mk(0, 0, 1, 32'h40,       0, 32'h0,        NOP,            32'h40,       0, 6);
        tbl[12] = mk(0, 0, 0, 32'h0,        1, 32'h40,       ins(32'h40),    32'h44,       0, 7);
        tbl[13] = mk(0, 1, 1, 32'h33,       0, 32'h0,        NOP,            32'h30,       1, 7);
        tbl[14] = mk(0, 0, 0, 32'h0,        1, 32'h30,       ins(32'h30),    32'h34,       0, 8);
        tbl[15] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       NOP,            32'hFFFF_FFFC, 0, 8);
        tbl[16] = mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, ins(32'hFFFF_FFFC), 32'h0,   0, 9);
        tbl[17] = mk(0, 0, 0, 32'h0,        1, 32'h0,        32'h0010_2083,  32'h4,        0, 10);

        // Reset held three cycles
        drive(1, 0, 0, 0, 32'h0);
        repeat (3) step();
        chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_pc4", id_pc4_o, 32'h0);
        chk("rst_instr", id_instr_o, NOP);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_mis", {31'h0, misalign_o}, 32'h0);
        chk("rst_cnt", fetch_count_o, 32'h0);

        for (int i = 0; i < 18; i++) begin
            drive(0, tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].rpc);
            step();
            chk($sformatf("v%0d_valid", i), {31'h0, id_valid_o}, {31'h0, tbl[i].exp_valid});
            chk($sformatf("v%0d_instr", i), id_instr_o, tbl[i].exp_instr);
            chk($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].exp_addr);
            chk($sformatf("v%0d_mis", i), {31'h0, misalign_o}, {31'h0, tbl[i].exp_mis});
            chk($sformatf("v%0d_cnt", i), fetch_count_o, tbl[i].exp_cnt);
            if (tbl[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), id_pc_o, tbl[i].exp_pc);
                chk($sformatf("v%0d_pc4", i), id_pc4_o, tbl[i].exp_pc + 32'd4);
            end
        end

        // Stall at pc=8 with undefined memory data
        drive(1, 0, 0, 0, 32'h0);
        step();
        drive(0, 0, 0, 0, 32'h0);
        repeat (2) step();
        drive(0, 1, 0, 0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stall_addr", imem_addr_o, 32'h8);
            chk("stall_pc", id_pc_o, 32'h4);
            chk("stall_instr", id_instr_o, ins(32'h4));
            chk("stall_cnt", fetch_count_o, 32'h2);
        end
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("resume_pc", id_pc_o, 32'h8);
        chk("resume_instr", id_instr_o, ins(32'h8));
        chk("resume_cnt", fetch_count_o, 32'h3);
        chk("resume_addr", imem_addr_o, 32'hC);

        // Reset during an active stall
        drive(1, 1, 0, 0, 32'h0);
        step();
        chk("rst_stall_addr", imem_addr_o, 32'h0);
        chk("rst_stall_valid", {31'h0, id_valid_o}, 32'h0);
        chk("rst_stall_cnt", fetch_count_o, 32'h0);
        chk("rst_stall_instr", id_instr_o, NOP);

        // Reset during a misaligned redirect discards it
        drive(0, 0, 0, 1, 32'h13);
        step();
        chk("redir_mis", {31'h0, misalign_o}, 32'h1);
        chk("redir_addr", imem_addr_o, 32'h10);
        drive(1, 0, 0, 1, 32'h13);
        step();
        chk("rst_redir_mis", {31'h0, misalign_o}, 32'h0);
        chk("rst_redir_addr", imem_addr_o, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        step();
        chk("post_rst_valid", {31'h0, id_valid_o}, 32'h1);
        chk("post_rst_pc", id_pc_o, 32'h0);
        chk("post_rst_cnt", fetch_count_o, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
